// File: rtl/note_player_pkg.sv
// rtl/note_player_pkg.sv - shared note constants, FSM state type and note-word decode
//
// Purpose: note half-periods at 100 MHz, octave codes, player FSM states and
//          the note-word to half-period decode used by note_player.
// Ports:   none (package).

package note_player_pkg;

  localparam int NOTE_WORD_W = 10;
  localparam int HP_WIDTH    = 20;

  // Mid-octave half-periods in 100 MHz clock cycles.
  localparam logic [HP_WIDTH-1:0] NOTE_HP_DO  = 20'd191110;
  localparam logic [HP_WIDTH-1:0] NOTE_HP_RE  = 20'd170265;
  localparam logic [HP_WIDTH-1:0] NOTE_HP_MI  = 20'd151685;
  localparam logic [HP_WIDTH-1:0] NOTE_HP_FA  = 20'd143172;
  localparam logic [HP_WIDTH-1:0] NOTE_HP_SOL = 20'd127551;
  localparam logic [HP_WIDTH-1:0] NOTE_HP_LA  = 20'd113636;
  localparam logic [HP_WIDTH-1:0] NOTE_HP_SI  = 20'd101239;

  typedef enum logic [1:0] {
    OCT_MID     = 2'b00,
    OCT_HIGH    = 2'b01,
    OCT_LOW     = 2'b10,
    OCT_ALT_MID = 2'b11
  } octave_e;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_REWIND = 3'd1,
    ST_REQ    = 3'd2,
    ST_WAIT   = 3'd3,
    ST_PLAY   = 3'd4,
    ST_GAP    = 3'd5
  } state_e;

  // Note word: [9:8] octave, [7:1] one-hot do..si, [0] reserved.
  // Returns 0 for a rest; the caller gates the tone on word[7:1] anyway.
  function automatic logic [HP_WIDTH-1:0] note_half_period(input logic [NOTE_WORD_W-1:0] word);
    logic [HP_WIDTH-1:0] base;
    base = '0;
    // Scanned from the top down so the lowest set note bit is assigned last and wins.
    if (word[7]) base = NOTE_HP_SI;
    if (word[6]) base = NOTE_HP_LA;
    if (word[5]) base = NOTE_HP_SOL;
    if (word[4]) base = NOTE_HP_FA;
    if (word[3]) base = NOTE_HP_MI;
    if (word[2]) base = NOTE_HP_RE;
    if (word[1]) base = NOTE_HP_DO;
    case (word[9:8])
      OCT_HIGH: base = base >> 1;
      // Largest low-octave value (do) is 382220, still inside 20 bits.
      OCT_LOW:  base = base << 1;
      default:  base = base;
    endcase
    return base;
  endfunction

endpackage

// File: rtl/note_player_tone_gen.sv
// rtl/note_player_tone_gen.sv - square-wave generator driven by a half-period count
//
// Purpose: while en is high, toggles the wave every half_period cycles; while en
//          is low, the counter and the wave are held at 0.
// Ports:
//   clk          in   1   system clock
//   rst_n        in   1   asynchronous active-low reset
//   en           in   1   tone enable
//   half_period  in   20  cycles per half wave
//   wave         out  1   square wave, forced low whenever en is low

module tone_gen
  import note_player_pkg::*;
(
  input  logic                clk,
  input  logic                rst_n,
  input  logic                en,
  input  logic [HP_WIDTH-1:0] half_period,
  output logic                wave
);

  logic [HP_WIDTH-1:0] cnt_q;
  logic                wave_q;
  logic                at_end;

  // Compare one bit wider so a half_period of 0 or 1 toggles every cycle
  // instead of wrapping.
  assign at_end = ({1'b0, cnt_q} + 21'd1) >= {1'b0, half_period};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      wave_q <= 1'b0;
    end else if (!en) begin
      cnt_q  <= '0;
      wave_q <= 1'b0;
    end else if (at_end) begin
      cnt_q  <= '0;
      wave_q <= ~wave_q;
    end else begin
      cnt_q  <= cnt_q + 20'd1;
    end
  end

  // Gated so silence is immediate when the note ends, not one cycle later.
  assign wave = en & wave_q;

endmodule

// File: rtl/note_player.sv
// rtl/note_player.sv - plays a song from a note memory onto a buzzer
//
// Purpose: rewinds the note memory, fetches one note at a time, sounds it for
//          NOTE_CYCLES, stays silent for GAP_CYCLES, and repeats until the
//          memory runs out (done) or stop aborts playback.
// Ports:
//   clk           in   1   system clock
//   rst_n         in   1   asynchronous active-low reset
//   start         in   1   begin playback from the first note (ignored while playing)
//   stop          in   1   abort playback
//   read_en       out  1   fetch request to the note memory
//   read_rst      out  1   rewind of the memory read pointer
//   data_in       in   10  note word, valid the cycle after read_en
//   output_ready  in   1   memory has a note, sampled the cycle after read_en
//   buzzer        out  1   square-wave audio
//   playing       out  1   high in every state except idle
//   done          out  1   pulse on natural end of song
//   cur_note      out  10  note word currently held

module note_player
  import note_player_pkg::*;
#(
  parameter int          DATA_WIDTH  = NOTE_WORD_W,
  parameter int unsigned NOTE_CYCLES = 25_000_000,
  parameter int unsigned GAP_CYCLES  = 2_500_000,
  parameter int unsigned TONE_SHIFT  = 0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  stop,
  output logic                  read_en,
  output logic                  read_rst,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  output_ready,
  output logic                  buzzer,
  output logic                  playing,
  output logic                  done,
  output logic [DATA_WIDTH-1:0] cur_note
);

  localparam logic [31:0] NOTE_LOAD = 32'(NOTE_CYCLES - 1);
  localparam logic [31:0] GAP_LOAD  = 32'(GAP_CYCLES - 1);

  state_e                state_q, state_d;
  logic [31:0]           cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] cur_note_q, cur_note_d;
  logic                  read_en_q, read_en_d;
  logic                  read_rst_q, read_rst_d;
  logic                  done_q, done_d;

  logic                  tone_en;
  logic [HP_WIDTH-1:0]   half_period;

  // read_rst, read_en and done are registered from the next state so a stop
  // can issue its rewind pulse in the same cycle the FSM lands in idle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      cur_note_q <= '0;
      read_en_q  <= 1'b0;
      read_rst_q <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      cur_note_q <= cur_note_d;
      read_en_q  <= read_en_d;
      read_rst_q <= read_rst_d;
      done_q     <= done_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    cur_note_d = cur_note_q;
    read_en_d  = 1'b0;
    read_rst_d = 1'b0;
    done_d     = 1'b0;

    if (stop && state_q != ST_IDLE) begin
      // Abort: silence, forget the note and rewind the memory. No done pulse.
      state_d    = ST_IDLE;
      cnt_d      = '0;
      cur_note_d = '0;
      read_rst_d = 1'b1;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start && !stop) state_d = ST_REWIND;
        end
        ST_REWIND: state_d = ST_REQ;
        ST_REQ:    state_d = ST_WAIT;
        ST_WAIT: begin
          if (output_ready) begin
            cur_note_d = data_in;
            cnt_d      = NOTE_LOAD;
            state_d    = ST_PLAY;
          end else begin
            cur_note_d = '0;
            done_d     = 1'b1;
            state_d    = ST_IDLE;
          end
        end
        ST_PLAY: begin
          if (cnt_q == '0) begin
            if (GAP_CYCLES == 0) begin
              state_d = ST_REQ;
            end else begin
              cnt_d   = GAP_LOAD;
              state_d = ST_GAP;
            end
          end else begin
            cnt_d = cnt_q - 32'd1;
          end
        end
        ST_GAP: begin
          if (cnt_q == '0) state_d = ST_REQ;
          else             cnt_d   = cnt_q - 32'd1;
        end
        default: state_d = ST_IDLE;
      endcase
    end

    read_en_d  = (state_d == ST_REQ);
    read_rst_d = read_rst_d | (state_d == ST_REWIND);
  end

  // A rest (no note bit set) keeps the tone generator disabled for the beat.
  assign tone_en     = (state_q == ST_PLAY) && (cur_note_q[7:1] != 7'd0);
  assign half_period = note_half_period(cur_note_q[NOTE_WORD_W-1:0]) >> TONE_SHIFT;

  tone_gen u_tone_gen (
    .clk         (clk),
    .rst_n       (rst_n),
    .en          (tone_en),
    .half_period (half_period),
    .wave        (buzzer)
  );

  assign read_en  = read_en_q;
  assign read_rst = read_rst_q;
  assign done     = done_q;
  assign playing  = (state_q != ST_IDLE);
  assign cur_note = cur_note_q;

endmodule

// File: tb/tb_note_player.sv
// tb/tb_note_player.sv - self-checking bench for note_player with a 16-entry ROM model

module tb_note_player;

  localparam int NOTE_C = 20;
  localparam int GAP_C  = 4;
  localparam int SHIFT  = 14;
  localparam int SLOT   = 2 + NOTE_C + GAP_C;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       stop = 1'b0;
  logic       read_en, read_rst, buzzer, playing, done;
  logic       output_ready = 1'b0;
  logic [9:0] data_in = '0;
  logic [9:0] cur_note;

  int n_cmp  = 0;
  int n_fail = 0;

  logic [9:0] rom [16];
  int         song_len = 0;
  int         ptr = 0;
  logic       trace_buzz [0:1023];
  int         base_hp [7] = '{191110, 170265, 151685, 143172, 127551, 113636, 101239};

  typedef struct packed {
    logic       read_en;
    logic       read_rst;
    logic       done;
    logic       playing;
    logic       buzzer;
    logic [9:0] cur_note;
  } exp_t;

  typedef struct {
    logic [9:0] word;
    int         exp_low;
  } vec_t;

  note_player #(
    .DATA_WIDTH  (10),
    .NOTE_CYCLES (NOTE_C),
    .GAP_CYCLES  (GAP_C),
    .TONE_SHIFT  (SHIFT)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .stop         (stop),
    .read_en      (read_en),
    .read_rst     (read_rst),
    .data_in      (data_in),
    .output_ready (output_ready),
    .buzzer       (buzzer),
    .playing      (playing),
    .done         (done),
    .cur_note     (cur_note)
  );

  always #5 clk = ~clk;

  // Note memory: registered response the cycle after read_en.
  always @(posedge clk) begin
    if (read_rst) begin
      ptr <= 0;
    end else if (read_en) begin
      if (ptr < song_len) begin
        data_in      <= rom[ptr];
        output_ready <= 1'b1;
        ptr          <= ptr + 1;
      end else begin
        output_ready <= 1'b0;
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  task automatic check(input string name, input int t, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s t=%0d actual=%0h expected=%0h", name, t, act, exp);
    end
  endtask

  // Half-period in cycles for a word, 0 for a rest.
  function automatic int half_of(input logic [9:0] w);
    int b;
    b = 0;
    for (int k = 0; k < 7; k++)
      if (w[k+1] && b == 0) b = base_hp[k];
    if (w[9:8] == 2'b01) b = b / 2;
    if (w[9:8] == 2'b10) b = b * 2;
    return b / (1 << SHIFT);
  endfunction

  // Expected outputs t cycles after start was sampled, from the slot timeline:
  // t=1 rewind, then each note is a SLOT-cycle slot of REQ, WAIT, PLAY, GAP.
  function automatic exp_t model(input int t, input int n, input int stop_at);
    exp_t e;
    int   u, i, ph, hp;
    e = '0;
    if (stop_at > 0 && t > stop_at) begin
      e.read_rst = (t == stop_at + 1);
      return e;
    end
    if (t == 1) begin
      e.read_rst = 1'b1;
      e.playing  = 1'b1;
      return e;
    end
    u  = t - 2;
    i  = u / SLOT;
    ph = u % SLOT;
    if (i < n) begin
      e.playing = 1'b1;
      e.read_en = (ph == 0);
      if (ph >= 2)    e.cur_note = rom[i];
      else if (i > 0) e.cur_note = rom[i-1];
      if (ph >= 2 && ph < 2 + NOTE_C) begin
        hp = half_of(rom[i]);
        if (hp > 0) e.buzzer = (((ph - 2) / hp) % 2) == 1;
      end
    end else if (i == n) begin
      if (ph <= 1) begin
        e.playing  = 1'b1;
        e.read_en  = (ph == 0);
        e.cur_note = rom[n-1];
      end else if (ph == 2) begin
        e.done = 1'b1;
      end
    end
    return e;
  endfunction

  task automatic run_song(input int n, input int stop_at, input int restart_at);
    exp_t e;
    int   tmax;
    song_len = n;
    tmax = (stop_at > 0) ? stop_at + 2 : 2 + SLOT * n + 3;
    @(negedge clk);
    start = 1'b1;
    for (int t = 1; t <= tmax; t++) begin
      @(negedge clk);
      start = 1'b0;
      stop  = 1'b0;
      e = model(t, n, stop_at);
      trace_buzz[t] = buzzer;
      check("read_en",  t, 32'(read_en),  32'(e.read_en));
      check("read_rst", t, 32'(read_rst), 32'(e.read_rst));
      check("done",     t, 32'(done),     32'(e.done));
      check("playing",  t, 32'(playing),  32'(e.playing));
      check("buzzer",   t, 32'(buzzer),   32'(e.buzzer));
      check("cur_note", t, 32'(cur_note), 32'(e.cur_note));
      if (t == stop_at)    stop  = 1'b1;
      if (t == restart_at) start = 1'b1;
    end
  endtask

  initial begin
    vec_t vecs [9];
    int   low;
    logic seen_high;

    vecs[0] = '{10'b0000000100, 10};  // re, mid
    vecs[1] = '{10'b0100000100, 5};   // re, high
    vecs[2] = '{10'b1000000100, 20};  // re, low: no toggle inside the beat
    vecs[3] = '{10'b0000000000, 20};  // rest
    vecs[4] = '{10'b0000000010, 11};  // do
    vecs[5] = '{10'b0010000000, 6};   // si
    vecs[6] = '{10'b0000011000, 9};   // mi and fa set: mi wins
    vecs[7] = '{10'b1100000100, 10};  // octave 11 is mid
    vecs[8] = '{10'b0000000101, 10};  // reserved bit ignored

    for (int k = 0; k < 16; k++) rom[k] = '0;

    // Reset state.
    repeat (3) @(negedge clk);
    check("reset_outputs", 0, 32'({read_en, read_rst, done, playing, buzzer, cur_note}), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check("idle_outputs", 0, 32'({read_en, read_rst, done, playing, buzzer, cur_note}), 32'd0);

    // start and stop together in idle: stay idle, no rewind.
    start = 1'b1;
    stop  = 1'b1;
    @(negedge clk);
    start = 1'b0;
    stop  = 1'b0;
    check("startstop_playing",  1, 32'(playing),  32'd0);
    check("startstop_read_rst", 1, 32'(read_rst), 32'd0);
    @(negedge clk);
    check("startstop_read_en",  2, 32'(read_en),  32'd0);

    // Single-note table: latch, octave, rest and priority decode.
    for (int v = 0; v < 9; v++) begin
      rom[0] = vecs[v].word;
      run_song(1, 0, 0);
      low = 0;
      seen_high = 1'b0;
      for (int t = 4; t < 4 + NOTE_C; t++) begin
        if (trace_buzz[t]) seen_high = 1'b1;
        else if (!seen_high) low++;
      end
      check("low_run", v, 32'(low), 32'(vecs[v].exp_low));
    end

    // Random songs, including a full 16-note one.
    for (int s = 0; s < 3; s++) begin
      for (int k = 0; k < 16; k++) rom[k] = 10'($urandom);
      run_song((s == 0) ? 16 : int'($urandom_range(1, 15)), 0, 0);
    end

    // Stop in PLAY of note 5, then replay from note 0.
    for (int k = 0; k < 16; k++) rom[k] = 10'($urandom);
    run_song(16, 2 + SLOT * 5 + 2 + 5, 0);
    run_song(16, 0, 0);

    // Reset in the gap of note 0: outputs drop without a clock edge.
    for (int k = 0; k < 16; k++) rom[k] = 10'($urandom) | 10'b0000000010;
    song_len = 2;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (24) @(negedge clk);
    check("gap_playing",  25, 32'(playing),  32'd1);
    check("gap_cur_note", 25, 32'(cur_note), 32'(rom[0]));
    #2;
    rst_n = 1'b0;
    #1;
    check("async_reset_outputs", 25, 32'({read_en, read_rst, done, playing, buzzer, cur_note}), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Replay after reset rewinds the memory; a start during PLAY is ignored.
    run_song(2, 0, 10);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
